// File: rtl/avalon_operand_loader.sv
// Avalon-MM host that loads operands A and B into the 3A-9B agent and returns its result on an Avalon-ST source.
// Optional result self-check enabled by defining LOADER_CHECK_EN (adds aso_out0_error).
module avalon_operand_loader #(
   parameter int unsigned N          = 32,
   parameter logic [7:0]  ADDR_A     = 8'h00,
   parameter logic [7:0]  ADDR_B     = 8'h01,
   parameter int unsigned RESULT_LAT = 2
) (
   input  logic            csi_clk,
   input  logic            rsi_arst_n,
   input  logic            asi_in0_valid,
   output logic            asi_in0_ready,
   input  logic [2*N-1:0]  asi_in0_data,
   output logic [7:0]      avm_m0_address,
   output logic            avm_m0_write,
   output logic [N-1:0]    avm_m0_writedata,
   input  logic            avm_m0_waitrequest,
   input  logic [N-1:0]    coe_R_in,
   output logic            aso_out0_valid,
   input  logic            aso_out0_ready,
   output logic [N-1:0]    aso_out0_data
`ifdef LOADER_CHECK_EN
   ,
   output logic            aso_out0_error
`endif
);

   localparam int unsigned CW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WAIT,
      OUT
   } state_t;

   state_t         state;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic [CW-1:0]  wait_cnt;
   logic [N-1:0]   in_a;
   logic [N-1:0]   in_b;

   assign in_a = asi_in0_data[N-1:0];
   assign in_b = asi_in0_data[2*N-1:N];

`ifdef LOADER_CHECK_EN
   logic [N-1:0] expected;
   logic [N-1:0] in_expected;

   assign in_expected = ((in_a << 1) + in_a) - ((in_b << 3) + in_b);
`endif

   always_ff @(posedge csi_clk or negedge rsi_arst_n) begin
      if (!rsi_arst_n) begin
         state            <= IDLE;
         asi_in0_ready    <= 1'b0;
         avm_m0_write     <= 1'b0;
         avm_m0_address   <= '0;
         avm_m0_writedata <= '0;
         aso_out0_valid   <= 1'b0;
         aso_out0_data    <= '0;
         op_a             <= '0;
         op_b             <= '0;
         wait_cnt         <= '0;
`ifdef LOADER_CHECK_EN
         expected         <= '0;
         aso_out0_error   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               asi_in0_ready <= 1'b1;
               if (asi_in0_valid && asi_in0_ready) begin
                  op_a             <= in_a;
                  op_b             <= in_b;
                  asi_in0_ready    <= 1'b0;
                  avm_m0_write     <= 1'b1;
                  avm_m0_address   <= ADDR_A;
                  avm_m0_writedata <= in_a;
`ifdef LOADER_CHECK_EN
                  expected         <= in_expected;
`endif
                  state            <= WR_A;
               end
            end

            // Bus outputs are preloaded for B on the A-accept edge so the writes run back-to-back.
            WR_A: begin
               if (!avm_m0_waitrequest) begin
                  avm_m0_address   <= ADDR_B;
                  avm_m0_writedata <= op_b;
                  state            <= WR_B;
               end else begin
                  avm_m0_address   <= ADDR_A;
                  avm_m0_writedata <= op_a;
               end
            end

            WR_B: begin
               if (!avm_m0_waitrequest) begin
                  avm_m0_write <= 1'b0;
                  wait_cnt     <= CW'(RESULT_LAT - 1);
                  state        <= WAIT;
               end
            end

            WAIT: begin
               if (wait_cnt == '0) begin
                  aso_out0_data  <= coe_R_in;
                  aso_out0_valid <= 1'b1;
`ifdef LOADER_CHECK_EN
                  aso_out0_error <= (coe_R_in != expected);
`endif
                  state          <= OUT;
               end else begin
                  wait_cnt <= wait_cnt - CW'(1);
               end
            end

            OUT: begin
               if (aso_out0_ready) begin
                  aso_out0_valid <= 1'b0;
`ifdef LOADER_CHECK_EN
                  aso_out0_error <= 1'b0;
`endif
                  asi_in0_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end

            default: begin
               avm_m0_write   <= 1'b0;
               aso_out0_valid <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_operand_loader.sv
// Scoreboard bench for avalon_operand_loader driving a behavioural 3A-9B agent on its bus.
module tb_avalon_operand_loader;

   localparam int N   = 32;
   localparam int LAT = 2;

   logic           csi_clk = 1'b0;
   logic           rsi_arst_n = 1'b0;
   logic           asi_in0_valid = 1'b0;
   logic           asi_in0_ready;
   logic [2*N-1:0] asi_in0_data = '0;
   logic [7:0]     avm_m0_address;
   logic           avm_m0_write;
   logic [N-1:0]   avm_m0_writedata;
   logic           avm_m0_waitrequest = 1'b0;
   logic [N-1:0]   coe_R_in;
   logic           aso_out0_valid;
   logic           aso_out0_ready = 1'b1;
   logic [N-1:0]   aso_out0_data;
`ifdef LOADER_CHECK_EN
   logic           aso_out0_error;
`endif

   avalon_operand_loader #(
      .N(N), .ADDR_A(8'h00), .ADDR_B(8'h01), .RESULT_LAT(LAT)
   ) dut (
      .csi_clk(csi_clk),
      .rsi_arst_n(rsi_arst_n),
      .asi_in0_valid(asi_in0_valid),
      .asi_in0_ready(asi_in0_ready),
      .asi_in0_data(asi_in0_data),
      .avm_m0_address(avm_m0_address),
      .avm_m0_write(avm_m0_write),
      .avm_m0_writedata(avm_m0_writedata),
      .avm_m0_waitrequest(avm_m0_waitrequest),
      .coe_R_in(coe_R_in),
      .aso_out0_valid(aso_out0_valid),
      .aso_out0_ready(aso_out0_ready),
      .aso_out0_data(aso_out0_data)
`ifdef LOADER_CHECK_EN
      ,
      .aso_out0_error(aso_out0_error)
`endif
   );

   always #5 csi_clk = ~csi_clk;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   int          cyc = 0;
   int          a_cyc = 0;
   int          b_cyc = 0;
   logic        prev_valid = 1'b0;

   typedef struct packed {
      logic [7:0]   addr;
      logic [N-1:0] data;
   } wr_t;

   typedef struct packed {
      logic [N-1:0] data;
      logic         err;
   } res_t;

   wr_t  wr_q[$];
   res_t res_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Agent model: operand registers written over the bus, result registered one cycle later.
   logic [N-1:0] ag_a, ag_b, ag_r;
   logic         force_en = 1'b0;
   logic [N-1:0] force_val = '0;

   always @(posedge csi_clk or negedge rsi_arst_n) begin
      if (!rsi_arst_n) begin
         ag_a <= '0;
         ag_b <= '0;
         ag_r <= '0;
      end else begin
         if (avm_m0_write && !avm_m0_waitrequest) begin
            if (avm_m0_address == 8'h00) ag_a <= avm_m0_writedata;
            if (avm_m0_address == 8'h01) ag_b <= avm_m0_writedata;
         end
         ag_r <= ag_a * 32'd3 - ag_b * 32'd9;
      end
   end

   assign coe_R_in = force_en ? force_val : ag_r;

   always @(posedge csi_clk) cyc++;

   // Bus write monitor
   always @(negedge csi_clk) begin
      if (rsi_arst_n && avm_m0_write && !avm_m0_waitrequest) begin
         chk("wr_expected", (wr_q.size() != 0), 1);
         if (wr_q.size() != 0) begin
            wr_t w;
            w = wr_q.pop_front();
            chk("wr_addr", avm_m0_address, w.addr);
            chk("wr_data", avm_m0_writedata, w.data);
         end
         if (avm_m0_address == 8'h00) a_cyc = cyc;
         else begin
            b_cyc = cyc;
            chk("ab_back_to_back", cyc - a_cyc, 1);
         end
      end
   end

   // Result stream monitor
   always @(negedge csi_clk) begin
      if (rsi_arst_n) begin
         if (aso_out0_valid && !prev_valid)
            chk("result_latency", cyc - b_cyc, LAT + 1);
         if (aso_out0_valid && aso_out0_ready) begin
            chk("res_expected", (res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
               res_t r;
               r = res_q.pop_front();
               chk("res_data", aso_out0_data, r.data);
`ifdef LOADER_CHECK_EN
               chk("res_error", aso_out0_error, r.err);
`endif
            end
         end
      end
      prev_valid = aso_out0_valid;
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] r,
                       input logic e, input bit full);
      bit ok;
      bit rdy;
      wr_q.push_back(wr_t'{addr: 8'h00, data: a});
      if (full) begin
         wr_q.push_back(wr_t'{addr: 8'h01, data: b});
         res_q.push_back(res_t'{data: r, err: e});
      end
      asi_in0_data  = {b, a};
      asi_in0_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge csi_clk);
         rdy = asi_in0_ready;
         @(posedge csi_clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1 asi_in0_valid = 1'b0;
      chk("pair_accepted", ok, 1);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !aso_out0_valid; i++) @(negedge csi_clk);
      chk("valid_seen", aso_out0_valid, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && (res_q.size() + wr_q.size()) != 0; i++) @(negedge csi_clk);
      chk("drain", res_q.size() + wr_q.size(), 0);
      @(posedge csi_clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge csi_clk);
      #1;
      chk("rst_in_ready", asi_in0_ready, 0);
      chk("rst_write", avm_m0_write, 0);
      chk("rst_address", avm_m0_address, 0);
      chk("rst_writedata", avm_m0_writedata, 0);
      chk("rst_valid", aso_out0_valid, 0);
      chk("rst_data", aso_out0_data, 0);
      #2 rsi_arst_n = 1'b1;
      @(posedge csi_clk);
      #1 chk("idle_ready", asi_in0_ready, 1);

      // Basic transaction with a one-cycle OUT
      send(5, 1, 6, 0, 1);
      wait_valid();
      @(negedge csi_clk);
      chk("one_cycle_out", aso_out0_valid, 0);
      wait_done();

      // Negative result and wrap
      send(0, 1, 32'hFFFF_FFF7, 0, 1);
      send(32'h8000_0000, 0, 32'h8000_0000, 0, 1);
      send(0, 32'hFFFF_FFFF, 9, 0, 1);
      wait_done();

      // Waitrequest stall on the A write
      avm_m0_waitrequest = 1'b1;
      send(7, 2, 3, 0, 1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_write", avm_m0_write, 1);
         chk("stall_addr", avm_m0_address, 8'h00);
         chk("stall_data", avm_m0_writedata, 7);
         if (i < 3) begin
            @(posedge csi_clk);
            #1;
         end
      end
      avm_m0_waitrequest = 1'b0;
      wait_done();

      // Output backpressure with a pair offered while not ready
      aso_out0_ready = 1'b0;
      send(100, 10, 210, 0, 1);
      wait_valid();
      asi_in0_data  = {32'd0, 32'd1};
      asi_in0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge csi_clk);
         chk("bp_valid", aso_out0_valid, 1);
         chk("bp_data", aso_out0_data, 210);
         chk("bp_in_ready", asi_in0_ready, 0);
      end
      @(posedge csi_clk);
      #1 aso_out0_ready = 1'b1;
      send(1, 0, 3, 0, 1);
      wait_done();

      // Reset in the middle of the B write
      send(9, 9, 0, 0, 0);
      @(posedge csi_clk);
      #2 rsi_arst_n = 1'b0;
      #1;
      chk("mid_rst_write", avm_m0_write, 0);
      chk("mid_rst_valid", aso_out0_valid, 0);
      chk("mid_rst_ready", asi_in0_ready, 0);
      chk("mid_rst_address", avm_m0_address, 0);
      wr_q.delete();
      res_q.delete();
      #3 rsi_arst_n = 1'b1;
      @(posedge csi_clk);
      #1 chk("post_rst_ready", asi_in0_ready, 1);
      send(2, 0, 6, 0, 1);
      wait_done();

      // Agent result forced wrong, then correct
      force_val = 1;
      force_en  = 1'b1;
      send(3, 1, 1, 1, 1);
      wait_done();
      force_en = 1'b0;
      send(3, 1, 0, 0, 1);
      wait_done();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
